// File: rtl/spi_reg_decoder.sv
// spi_reg_decoder: command/data byte-pair decoder sitting behind the SPI slave PHY.
// Decodes read/write commands, owns the 16-bit LED register, snapshots switches
// and registers the response byte the PHY shifts out during the following slot.
// Optional: define SPI_REG_SCRATCH_EN to add an 8-bit scratch register at addr 5.
module spi_reg_decoder #(
  parameter logic [7:0]  CHIP_ID   = 8'h07,
  parameter logic [3:0]  WR_NIBBLE = 4'hF,
  parameter logic [15:0] LED_RST   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_active,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [7:0]  tx_data,
  input  logic [15:0] switches,
  output logic [15:0] leds,
  output logic        cmd_err
);

  typedef enum logic {ST_CMD, ST_DATA} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  tx_q, tx_d;
  logic [15:0] leds_q, leds_d;
  logic        err_q, err_d;
`ifdef SPI_REG_SCRATCH_EN
  logic [7:0]  scratch_q, scratch_d;
`endif

  logic [7:0]  rd_val;
  logic        rd_ok;
  logic        wr_ok;
  logic        rx_is_wr;
  logic        cmd_is_wr;

  assign rx_is_wr  = (rx_data[7:4] == WR_NIBBLE);
  assign cmd_is_wr = (cmd_q[7:4] == WR_NIBBLE);

  // Decode the address of the byte currently on rx_data (used in the command slot).
  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b1;
    wr_ok  = 1'b0;
    case (rx_data[3:0])
      4'd0: rd_val = CHIP_ID;
      4'd1: rd_val = switches[7:0];
      4'd2: rd_val = switches[15:8];
      4'd3: begin rd_val = leds_q[7:0];  wr_ok = 1'b1; end
      4'd4: begin rd_val = leds_q[15:8]; wr_ok = 1'b1; end
`ifdef SPI_REG_SCRATCH_EN
      4'd5: begin rd_val = scratch_q;    wr_ok = 1'b1; end
`endif
      default: rd_ok = 1'b0;
    endcase
  end

  // Next-state logic: frame end overrides any byte arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    tx_d    = tx_q;
    leds_d  = leds_q;
    err_d   = 1'b0;
`ifdef SPI_REG_SCRATCH_EN
    scratch_d = scratch_q;
`endif
    if (!frame_active) begin
      state_d = ST_CMD;
      tx_d    = '0;
    end else if (rx_valid) begin
      case (state_q)
        ST_CMD: begin
          cmd_d   = rx_data;
          state_d = ST_DATA;
          if (rx_is_wr) begin
            tx_d  = '0;
            err_d = ~wr_ok;
          end else begin
            tx_d  = rd_val;
            err_d = ~rd_ok;
          end
        end
        ST_DATA: begin
          state_d = ST_CMD;
          tx_d    = '0;
          if (cmd_is_wr) begin
            case (cmd_q[3:0])
              4'd3: leds_d[7:0]  = rx_data;
              4'd4: leds_d[15:8] = rx_data;
`ifdef SPI_REG_SCRATCH_EN
              4'd5: scratch_d    = rx_data;
`endif
              default: ;
            endcase
          end
        end
        default: state_d = ST_CMD;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CMD;
      cmd_q   <= '0;
      tx_q    <= '0;
      leds_q  <= LED_RST;
      err_q   <= 1'b0;
`ifdef SPI_REG_SCRATCH_EN
      scratch_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      tx_q    <= tx_d;
      leds_q  <= leds_d;
      err_q   <= err_d;
`ifdef SPI_REG_SCRATCH_EN
      scratch_q <= scratch_d;
`endif
    end
  end

  assign tx_data = tx_q;
  assign leds    = leds_q;
  assign cmd_err = err_q;

endmodule

// File: tb/tb_spi_reg_decoder.sv
// Testbench for spi_reg_decoder: directed steps from the test plan followed by a
// randomized byte stream, all checked against a byte-pair transaction model.
module tb_spi_reg_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_active;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data;
  logic [15:0] switches;
  logic [15:0] leds;
  logic        cmd_err;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned step     = 0;

  // Transaction-level model state
  logic [15:0] m_leds;
  logic [7:0]  m_scratch;
  logic [7:0]  m_tx;
  logic [7:0]  m_cmd;
  bit          m_pend;
  bit          m_err;

`ifdef SPI_REG_SCRATCH_EN
  localparam bit SCRATCH = 1'b1;
`else
  localparam bit SCRATCH = 1'b0;
`endif

  spi_reg_decoder #(
    .CHIP_ID  (8'h07),
    .WR_NIBBLE(4'hF),
    .LED_RST  (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_active(frame_active),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_data     (tx_data),
    .switches    (switches),
    .leds        (leds),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s step %0d: observed %h expected %h", tag, step, obs, exp);
    end
  endtask

  // Apply a response for a command byte: readable value or error per address map.
  task automatic model_cmd(input logic [7:0] b);
    bit wr;
    wr     = (b[7:4] == 4'hF);
    m_cmd  = b;
    m_pend = 1'b1;
    m_tx   = 8'h00;
    m_err  = 1'b0;
    if (wr) begin
      m_err = !((b[3:0] == 4'd3) || (b[3:0] == 4'd4) || (SCRATCH && b[3:0] == 4'd5));
    end else begin
      case (b[3:0])
        4'd0: m_tx = 8'h07;
        4'd1: m_tx = switches[7:0];
        4'd2: m_tx = switches[15:8];
        4'd3: m_tx = m_leds[7:0];
        4'd4: m_tx = m_leds[15:8];
        4'd5: if (SCRATCH) m_tx = m_scratch; else m_err = 1'b1;
        default: m_err = 1'b1;
      endcase
    end
  endtask

  task automatic model_data(input logic [7:0] b);
    m_pend = 1'b0;
    m_tx   = 8'h00;
    m_err  = 1'b0;
    if (m_cmd[7:4] == 4'hF) begin
      if (m_cmd[3:0] == 4'd3) m_leds = {m_leds[15:8], b};
      else if (m_cmd[3:0] == 4'd4) m_leds = {b, m_leds[7:0]};
      else if (SCRATCH && m_cmd[3:0] == 4'd5) m_scratch = b;
    end
  endtask

  // One clock: drive inputs at the falling edge, advance model, check next falling edge.
  task automatic cycle(input bit v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(negedge clk);
    rx_valid = 1'b0;
    step++;
    if (rst) begin
      m_leds = 16'h0000; m_scratch = 8'h00; m_tx = 8'h00; m_err = 1'b0; m_pend = 1'b0;
    end else if (!frame_active) begin
      m_tx = 8'h00; m_err = 1'b0; m_pend = 1'b0;
    end else if (v) begin
      if (!m_pend) model_cmd(d);
      else model_data(d);
    end else begin
      m_err = 1'b0;
    end
    check("tx_data", {8'h00, tx_data}, {8'h00, m_tx});
    check("cmd_err", {15'h0, cmd_err}, {15'h0, m_err});
    check("leds", leds, m_leds);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic pair(input logic [7:0] c, input logic [7:0] d, input int unsigned gap);
    cycle(1'b1, c);
    idle(gap);
    cycle(1'b1, d);
  endtask

  initial begin
    rst = 1'b1; frame_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; switches = 16'h0000;
    m_leds = 16'h0000; m_scratch = 8'h00; m_tx = 8'h00; m_cmd = 8'h00; m_pend = 1'b0; m_err = 1'b0;
    @(negedge clk);
    cycle(1'b0, 8'h00);
    cycle(1'b1, 8'hF3);
    rst = 1'b0;
    frame_active = 1'b1;
    idle(1);

    // Chip ID
    cycle(1'b1, 8'h00);
    idle(2);
    cycle(1'b1, 8'h00);
    idle(1);

    // Switches, including a change while the read response is held
    switches = 16'h00FF;
    pair(8'h01, 8'h01, 1);
    pair(8'h02, 8'h02, 0);
    cycle(1'b1, 8'h01);
    switches = 16'h1234;
    idle(2);
    cycle(1'b1, 8'h01);
    idle(1);

    // LED writes and read-back
    pair(8'hF3, 8'hFF, 1);
    pair(8'hF4, 8'hAA, 0);
    pair(8'h03, 8'h00, 1);
    pair(8'h04, 8'h00, 0);
    idle(1);

    // Illegal commands
    pair(8'h0C, 8'h00, 1);
    pair(8'hF1, 8'h55, 1);
    idle(1);

    // Frame abort mid-pair, with a byte arriving while deselected
    cycle(1'b1, 8'hF3);
    frame_active = 1'b0;
    idle(1);
    cycle(1'b1, 8'h11);
    idle(1);
    frame_active = 1'b1;
    pair(8'h77, 8'h00, 1);

    // Frame end in the same cycle as the data byte: byte dropped
    cycle(1'b1, 8'hF4);
    frame_active = 1'b0;
    cycle(1'b1, 8'h55);
    frame_active = 1'b1;
    pair(8'h03, 8'h00, 0);

    // Scratch register address (mapped only with the optional feature)
    pair(8'hF5, 8'h3C, 0);
    pair(8'h05, 8'h00, 1);

    // Reset mid-pair
    cycle(1'b1, 8'hF4);
    rst = 1'b1;
    cycle(1'b0, 8'h00);
    rst = 1'b0;
    pair(8'h00, 8'h00, 1);
    pair(8'h05, 8'h00, 0);

    // Randomized byte stream with occasional frame drops and switch changes
    for (int unsigned k = 0; k < 400; k++) begin
      int unsigned r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 5) switches = 16'($urandom);
      if (r < 4) begin
        frame_active = 1'b0;
        cycle(1'($urandom), 8'($urandom));
        frame_active = 1'b1;
      end else if (r < 20) begin
        cycle(1'b0, 8'h00);
      end else begin
        b = 8'($urandom);
        if ($urandom_range(0, 1) == 0) b[7:4] = 4'hF;
        if ($urandom_range(0, 3) != 0) b[3:0] = 4'($urandom_range(0, 6));
        cycle(1'b1, b);
      end
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_decoder.md
Name: spi_reg_decoder

Overview:
- Command/register stage directly downstream of the SPI slave byte PHY (sck/mosi/miso/ss, LSB-first).
- Consumes received bytes as command/data pairs and decodes read/write commands.
- Owns the LED output register and snapshots the switches.
- Presents the response byte for the PHY to shift out on MISO during the byte that follows a read command.

Parameters:
- CHIP_ID, 8'h07, value returned at address 0
- WR_NIBBLE, 4'hF, command[7:4] value that marks a write
- LED_RST, 16'h0000, LED register value after reset

Ports:
- clk, input, 1, system clock
- rst, input, 1, synchronous active-high reset
- frame_active, input, 1, ss asserted, already synchronised to clk by the PHY
- rx_valid, input, 1, one-cycle pulse: rx_data holds a complete received byte
- rx_data, input, 8, received byte
- tx_data, output, 8, byte the PHY loads and shifts out for the next byte slot
- switches, input, 16, board switches
- leds, output, 16, LED register
- cmd_err, output, 1, one-cycle pulse on an illegal command

Behaviour:
- One clock, synchronous active-high reset.
- Reset values: state=CMD, leds=LED_RST, tx_data=8'h00, cmd_err=0.
- Command byte format: [7:4]==WR_NIBBLE means write, any other value means read; [3:0]=addr.
- Read map:
  - 0 = CHIP_ID
  - 1 = switches[7:0]
  - 2 = switches[15:8]
  - 3 = leds[7:0]
  - 4 = leds[15:8]
  - 5..15 = 8'h00 with cmd_err
- Write map:
  - 3 = leds[7:0]
  - 4 = leds[15:8]
  - any other addr: no register change, cmd_err pulse
- FSM, two states:
  - CMD: on rx_valid, latch cmd; go to DATA.
  - DATA: on rx_valid, perform a pending write (if any); go to CMD.
- Read timing:
  - Cycle after the command rx_valid, tx_data = addressed value.
  - Switches are sampled in that cycle, not later.
  - tx_data holds until the DATA-state rx_valid, then returns to 8'h00 the next cycle.
- Write timing:
  - Cycle after the DATA rx_valid, the selected LED byte = rx_data.
  - The other LED byte is unchanged.
- tx_data is 8'h00 during every command byte slot and during write data slots.
- cmd_err timing: pulses the cycle after the command byte is decoded, never on the data byte.
- frame_active low (ss deasserted):
  - Forces state=CMD and tx_data=8'h00; any pending cmd is discarded.
  - leds is retained.
  - rx_valid while frame_active=0 is ignored.
- rst mid-pair: same as frame end, plus leds=LED_RST.
- rx_valid and frame_active falling in the same cycle: the frame end wins and the byte is dropped.
- Back-to-back rx_valid on consecutive cycles must be handled; no dead cycles are required between bytes.

Optional Feature:
- Macro: SPI_REG_SCRATCH_EN.
- When defined:
  - Address 5 is an 8-bit scratch register: readable, written by a 0xF5 command.
  - Resets to 8'h00; not cleared by frame end.
  - Neither read 0x05 nor write 0xF5 raises cmd_err.
- When undefined:
  - Address 5 behaves like any unmapped address: read returns 8'h00 with cmd_err; 0xF5 raises cmd_err with no register change.

Test Plan:
- Chip ID: after reset, frame_active=1, send bytes 0x00 then 0x00 -> tx_data=0x07 the cycle after the first rx_valid; 0x00 after the second; leds=0x0000; cmd_err never pulses.
- Switches: switches=0x00FF, send 0x01,0x01 -> tx 0xFF; send 0x02,0x02 -> tx 0x00. Change switches to 0x1234 while in DATA after cmd 0x01 -> tx stays 0xFF.
- LED writes: send 0xF3,0xFF -> leds=0x00FF one cycle after the data rx_valid; send 0xF4,0xAA -> leds=0xAAFF; read pairs 0x03/0x04 -> tx 0xFF then 0xAA.
- Illegal commands: send 0x0C,0x00 -> cmd_err one pulse, tx 0x00; send 0xF1,0x55 -> cmd_err, leds unchanged.
- Frame abort: send 0xF3, drop frame_active for 3 cycles, raise it, send 0x77,0x00 -> leds unchanged, 0x77 decoded as a read command (addr 7: tx 0x00, cmd_err).
- Reset mid-pair: leds=0xAAFF, send 0xF4, assert rst 1 cycle, send 0x00,0x00 -> leds=0x0000, tx=0x07. With SPI_REG_SCRATCH_EN, also write 0xF5,0x3C then read 0x05,0x00 -> tx 0x3C.
